mouse_cursor_tracker: RTL and testbench
=======================================

Name: mouse_cursor_tracker

Overview:
Consumes decoded PS/2 mouse packets from the mouse interface adapter and maintains an absolute, clamped cursor position plus registered button state. It handshakes each packet with a one-cycle Read pulse and converts 9-bit two's-complement increments into screen coordinates, with Y inverted for screen orientation. It sits between the PS/2 mouse adapter and the display/overlay logic.

Parameters:
SCREEN_W, 640, horizontal extent; CursorX is held within 0..SCREEN_W-1
SCREEN_H, 480, vertical extent; CursorY is held within 0..SCREEN_H-1
POS_W, 10, width of the position outputs; must satisfy 2^POS_W >= max(SCREEN_W, SCREEN_H)
SPEED_SHIFT, 0, arithmetic left shift applied to increments; legal values 0..2

Ports:
Clk  in  1  system clock, single clock domain
Reset  in  1  synchronous, active-high reset
DataReady  in  1  adapter has a packet; stays high until Read is seen
XIncrement  in  9  signed X delta, two's complement
YIncrement  in  9  signed Y delta, two's complement; positive means up
BtLeft / BtRight / BtMiddle  in  1 each  button levels from the adapter
ErrorNoAck  in  1  adapter reports that the mouse did not acknowledge
Recenter  in  1  synchronous request to move the cursor to the screen centre
Read  out  1  one-cycle acknowledge pulse to the adapter
CursorX  out  POS_W  current X position
CursorY  out  POS_W  current Y position
Buttons  out  3  registered {middle, right, left}
Moved  out  1  one-cycle pulse when CursorX or CursorY changes
ButtonChange  out  1  one-cycle pulse when Buttons changes
MouseFault  out  1  sticky copy of ErrorNoAck

Behaviour:
- Reset values:
  - CursorX = SCREEN_W/2, CursorY = SCREEN_H/2
  - Buttons = 0, Read = 0, Moved = 0, ButtonChange = 0, MouseFault = 0
  - state = IDLE
- All outputs are registered.
- FSM states: IDLE, ACK, CALC, COMMIT, DRAIN.
- IDLE: when DataReady = 1, latch XIncrement, YIncrement and the three buttons, then go to ACK.
- ACK: Read = 1 for exactly this cycle; go to CALC.
- CALC: compute in 13-bit signed arithmetic:
  - dx = sext(XIncrement) <<< SPEED_SHIFT, dy = sext(YIncrement) <<< SPEED_SHIFT
  - nx = CursorX + dx
  - ny = CursorY - dy (Y is inverted: positive YIncrement moves the cursor up the screen)
  - Register nx and ny; go to COMMIT.
- COMMIT:
  - Clamp nx to 0..SCREEN_W-1 and ny to 0..SCREEN_H-1; a negative result clamps to 0.
  - Write CursorX, CursorY and Buttons.
  - Moved = 1 if either clamped coordinate differs from the old value.
  - ButtonChange = 1 if Buttons differs from its old value.
  - Go to DRAIN.
- DRAIN: stay until DataReady = 0, then go to IDLE. This guarantees one update per packet and no double-consume.
- Latency: DataReady rising edge to Read = 2 cycles; to the updated CursorX/CursorY and pulses = 4 cycles.
- Saturation: at an edge, further motion in the same direction leaves the position unchanged and Moved = 0; buttons are still updated.
- Zero deltas: position unchanged, Moved = 0, Read is still pulsed.
- Recenter:
  - Sets CursorX/CursorY to the centre on the next edge in any state.
  - If it coincides with COMMIT, Recenter wins: the packet's position update is discarded, but buttons are still committed.
  - Moved pulses if the centre differs from the old position.
  - The FSM flow is not altered.
- ErrorNoAck: when high on any cycle, MouseFault goes to 1 and stays set until Reset. Packets continue to be processed.
- Reset mid-transaction: the FSM returns to IDLE and the latched packet is discarded. If DataReady is still high after reset, the packet is consumed as a new one.

Decomposition:
- Shared package mouse_pkg holds:
  - the state encoding (IDLE=0, ACK=1, CALC=2, COMMIT=3, DRAIN=4)
  - the internal arithmetic width constant (13)
  - the button index constants (L=0, R=1, M=2)
- One natural sub-module: axis_clamp. It is instanced twice, takes a signed 13-bit input and a limit parameter, and returns the clamped POS_W value.

Test Plan:
- Reset, then DataReady with X=+5, Y=+3 -> Read pulses 2 cycles after DataReady; 4 cycles after, CursorX=325, CursorY=237, Moved=1.
- At CursorX=638, send X=+10 -> CursorX=639. Send another X=+1 -> CursorX=639, Moved=0. With Y=9'h1F0 (-16) from CursorY=470 -> CursorY=479.
- X=9'h100 (-256) from CursorX=100 -> CursorX=0. With SPEED_SHIFT=2, X=+4 from 320 -> 336.
- Hold DataReady high for 10 cycles after Read -> exactly one Read and one update; the next packet is accepted only after DataReady drops.
- Assert Recenter in the COMMIT cycle of an X=+20 packet with BtLeft=1 -> Cursor=(320,240), Buttons=3'b001, ButtonChange=1.
- Pulse ErrorNoAck for 1 cycle -> MouseFault=1 persists; the next packet still updates the cursor; Reset clears MouseFault.

Source files
------------

// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared constants and helpers for the mouse cursor tracker
package mouse_pkg;

    localparam int ARITH_W = 13;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACK    = 3'd1;
    localparam logic [2:0] ST_CALC   = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;

    // Sign-extend a 9-bit PS/2 delta to the arithmetic width, then apply speed scaling
    function automatic logic signed [ARITH_W-1:0] scale_delta(input logic [8:0] inc, input int shift);
        logic signed [ARITH_W-1:0] ext;
        ext = $signed({{(ARITH_W-9){inc[8]}}, inc});
        return ext <<< shift;
    endfunction

endpackage

// File: rtl/axis_clamp.sv
// rtl/axis_clamp.sv - clamps a signed coordinate into 0..LIMIT-1
module axis_clamp
    import mouse_pkg::*;
#(
    parameter int LIMIT = 640,
    parameter int POS_W = 10
) (
    input  logic signed [ARITH_W-1:0] i_value,
    output logic        [POS_W-1:0]   o_value
);

    localparam logic signed [ARITH_W-1:0] MAX_S = ARITH_W'(LIMIT - 1);
    localparam logic        [POS_W-1:0]   MAX_P = POS_W'(LIMIT - 1);

    always_comb begin
        o_value = i_value[POS_W-1:0];
        if (i_value < 0) begin
            o_value = '0;
        end else if (i_value > MAX_S) begin
            o_value = MAX_P;
        end
    end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// rtl/mouse_cursor_tracker.sv - absolute clamped cursor and button tracking from PS/2 packets
module mouse_cursor_tracker
    import mouse_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int POS_W       = 10,
    parameter int SPEED_SHIFT = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_data_ready,
    input  logic [8:0]       i_x_increment,
    input  logic [8:0]       i_y_increment,
    input  logic             i_bt_left,
    input  logic             i_bt_right,
    input  logic             i_bt_middle,
    input  logic             i_error_no_ack,
    input  logic             i_recenter,
    output logic             o_read,
    output logic [POS_W-1:0] o_cursor_x,
    output logic [POS_W-1:0] o_cursor_y,
    output logic [2:0]       o_buttons,
    output logic             o_moved,
    output logic             o_button_change,
    output logic             o_mouse_fault
);

    localparam logic [POS_W-1:0] CENTER_X = POS_W'(SCREEN_W / 2);
    localparam logic [POS_W-1:0] CENTER_Y = POS_W'(SCREEN_H / 2);

    logic [2:0]                r_state;
    logic [8:0]                r_x_inc;
    logic [8:0]                r_y_inc;
    logic [2:0]                r_btn_lat;
    logic signed [ARITH_W-1:0] r_nx;
    logic signed [ARITH_W-1:0] r_ny;
    logic [POS_W-1:0]          r_cursor_x;
    logic [POS_W-1:0]          r_cursor_y;
    logic [2:0]                r_buttons;
    logic                      r_read;
    logic                      r_moved;
    logic                      r_button_change;
    logic                      r_mouse_fault;

    logic [POS_W-1:0]          w_clamp_x;
    logic [POS_W-1:0]          w_clamp_y;
    logic signed [ARITH_W-1:0] w_old_x;
    logic signed [ARITH_W-1:0] w_old_y;

    assign w_old_x = $signed({{(ARITH_W-POS_W){1'b0}}, r_cursor_x});
    assign w_old_y = $signed({{(ARITH_W-POS_W){1'b0}}, r_cursor_y});

    axis_clamp #(.LIMIT(SCREEN_W), .POS_W(POS_W)) u_clamp_x (
        .i_value (r_nx),
        .o_value (w_clamp_x)
    );

    axis_clamp #(.LIMIT(SCREEN_H), .POS_W(POS_W)) u_clamp_y (
        .i_value (r_ny),
        .o_value (w_clamp_y)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_x_inc         <= '0;
            r_y_inc         <= '0;
            r_btn_lat       <= '0;
            r_nx            <= '0;
            r_ny            <= '0;
            r_cursor_x      <= CENTER_X;
            r_cursor_y      <= CENTER_Y;
            r_buttons       <= '0;
            r_read          <= 1'b0;
            r_moved         <= 1'b0;
            r_button_change <= 1'b0;
            r_mouse_fault   <= 1'b0;
        end else begin
            // Read is registered off the ACK state so it lands two cycles after DataReady
            r_read          <= (r_state == ST_ACK);
            r_moved         <= 1'b0;
            r_button_change <= 1'b0;
            if (i_error_no_ack) begin
                r_mouse_fault <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_data_ready) begin
                        r_x_inc          <= i_x_increment;
                        r_y_inc          <= i_y_increment;
                        r_btn_lat[BTN_L] <= i_bt_left;
                        r_btn_lat[BTN_R] <= i_bt_right;
                        r_btn_lat[BTN_M] <= i_bt_middle;
                        r_state          <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_CALC;
                end
                ST_CALC: begin
                    // Screen Y grows downward, so a positive mouse Y subtracts
                    r_nx    <= w_old_x + scale_delta(r_x_inc, SPEED_SHIFT);
                    r_ny    <= w_old_y - scale_delta(r_y_inc, SPEED_SHIFT);
                    r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_buttons       <= r_btn_lat;
                    r_button_change <= (r_btn_lat != r_buttons);
                    r_cursor_x      <= w_clamp_x;
                    r_cursor_y      <= w_clamp_y;
                    r_moved         <= (w_clamp_x != r_cursor_x) || (w_clamp_y != r_cursor_y);
                    r_state         <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!i_data_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Recenter overrides any position written above, including a COMMIT
            if (i_recenter) begin
                r_cursor_x <= CENTER_X;
                r_cursor_y <= CENTER_Y;
                r_moved    <= (CENTER_X != r_cursor_x) || (CENTER_Y != r_cursor_y);
            end
        end
    end

    assign o_read          = r_read;
    assign o_cursor_x      = r_cursor_x;
    assign o_cursor_y      = r_cursor_y;
    assign o_buttons       = r_buttons;
    assign o_moved         = r_moved;
    assign o_button_change = r_button_change;
    assign o_mouse_fault   = r_mouse_fault;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// tb/tb_mouse_cursor_tracker.sv - directed self-checking bench for mouse_cursor_tracker
module tb_mouse_cursor_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_ready = 1'b0;
    logic [8:0] x_inc = '0;
    logic [8:0] y_inc = '0;
    logic       bt_left = 1'b0;
    logic       bt_right = 1'b0;
    logic       bt_middle = 1'b0;
    logic       error_no_ack = 1'b0;
    logic       recenter = 1'b0;
    logic       read;
    logic [9:0] cursor_x;
    logic [9:0] cursor_y;
    logic [2:0] buttons;
    logic       moved;
    logic       button_change;
    logic       mouse_fault;

    logic       d2_data_ready = 1'b0;
    logic [8:0] d2_x_inc = '0;
    logic [8:0] d2_y_inc = '0;
    logic       d2_zero = 1'b0;
    logic       d2_read;
    logic [9:0] d2_cursor_x;
    logic [9:0] d2_cursor_y;
    logic [2:0] d2_buttons;
    logic       d2_moved;
    logic       d2_button_change;
    logic       d2_mouse_fault;

    int errors = 0;
    int checks = 0;
    int n_reads;
    int n_moved;
    logic read_at2;
    logic moved_snap;
    logic bc_snap;

    always #5 clk = ~clk;

    mouse_cursor_tracker #(.SCREEN_W(640), .SCREEN_H(480), .POS_W(10), .SPEED_SHIFT(0)) u_dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_data_ready    (data_ready),
        .i_x_increment   (x_inc),
        .i_y_increment   (y_inc),
        .i_bt_left       (bt_left),
        .i_bt_right      (bt_right),
        .i_bt_middle     (bt_middle),
        .i_error_no_ack  (error_no_ack),
        .i_recenter      (recenter),
        .o_read          (read),
        .o_cursor_x      (cursor_x),
        .o_cursor_y      (cursor_y),
        .o_buttons       (buttons),
        .o_moved         (moved),
        .o_button_change (button_change),
        .o_mouse_fault   (mouse_fault)
    );

    mouse_cursor_tracker #(.SCREEN_W(640), .SCREEN_H(480), .POS_W(10), .SPEED_SHIFT(2)) u_dut_fast (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_data_ready    (d2_data_ready),
        .i_x_increment   (d2_x_inc),
        .i_y_increment   (d2_y_inc),
        .i_bt_left       (d2_zero),
        .i_bt_right      (d2_zero),
        .i_bt_middle     (d2_zero),
        .i_error_no_ack  (d2_zero),
        .i_recenter      (d2_zero),
        .o_read          (d2_read),
        .o_cursor_x      (d2_cursor_x),
        .o_cursor_y      (d2_cursor_y),
        .o_buttons       (d2_buttons),
        .o_moved         (d2_moved),
        .o_button_change (d2_button_change),
        .o_mouse_fault   (d2_mouse_fault)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one packet from a negedge; samples over the 4-cycle update window plus hold cycles
    task automatic send_packet(input logic [8:0] x, input logic [8:0] y, input logic [2:0] btn,
                               input bit recenter_at_commit, input int hold);
        x_inc      = x;
        y_inc      = y;
        bt_left    = btn[0];
        bt_right   = btn[1];
        bt_middle  = btn[2];
        data_ready = 1'b1;
        n_reads    = 0;
        n_moved    = 0;
        for (int c = 1; c <= 4 + hold; c++) begin
            @(negedge clk);
            if (read === 1'b1) n_reads++;
            if (moved === 1'b1) n_moved++;
            if (c == 2) read_at2 = read;
            if (c == 3 && recenter_at_commit) recenter = 1'b1;
            if (c == 4) begin
                recenter   = 1'b0;
                moved_snap = moved;
                bc_snap    = button_change;
            end
        end
        data_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_x", 32'(cursor_x), 32'd320);
        check("reset_y", 32'(cursor_y), 32'd240);
        check("reset_buttons", 32'(buttons), 32'd0);
        check("reset_read", 32'(read), 32'd0);
        check("reset_moved", 32'(moved), 32'd0);
        check("reset_fault", 32'(mouse_fault), 32'd0);

        send_packet(9'd5, 9'd3, 3'b000, 1'b0, 0);
        check("p1_read_at_2", 32'(read_at2), 32'd1);
        check("p1_read_count", n_reads, 32'd1);
        check("p1_x", 32'(cursor_x), 32'd325);
        check("p1_y", 32'(cursor_y), 32'd237);
        check("p1_moved", 32'(moved_snap), 32'd1);

        send_packet(9'h0FF, 9'd0, 3'b000, 1'b0, 0);
        check("p2_x", 32'(cursor_x), 32'd580);
        send_packet(9'h03A, 9'd0, 3'b000, 1'b0, 0);
        check("p3_x", 32'(cursor_x), 32'd638);
        send_packet(9'd10, 9'd0, 3'b000, 1'b0, 0);
        check("right_clamp_x", 32'(cursor_x), 32'd639);
        check("right_clamp_moved", 32'(moved_snap), 32'd1);
        send_packet(9'd1, 9'd0, 3'b000, 1'b0, 0);
        check("right_sat_x", 32'(cursor_x), 32'd639);
        check("right_sat_moved", 32'(moved_snap), 32'd0);

        send_packet(9'd0, 9'h117, 3'b000, 1'b0, 0);
        check("down_y", 32'(cursor_y), 32'd470);
        send_packet(9'd0, 9'h1F0, 3'b000, 1'b0, 0);
        check("bottom_clamp_y", 32'(cursor_y), 32'd479);
        check("bottom_clamp_moved", 32'(moved_snap), 32'd1);

        send_packet(9'd1, 9'h1FF, 3'b010, 1'b0, 0);
        check("corner_sat_x", 32'(cursor_x), 32'd639);
        check("corner_sat_y", 32'(cursor_y), 32'd479);
        check("corner_sat_moved", 32'(moved_snap), 32'd0);
        check("corner_buttons", 32'(buttons), 32'd2);
        check("corner_btn_change", 32'(bc_snap), 32'd1);

        send_packet(9'd0, 9'd0, 3'b010, 1'b0, 0);
        check("zero_moved", 32'(moved_snap), 32'd0);
        check("zero_btn_change", 32'(bc_snap), 32'd0);
        check("zero_read_count", n_reads, 32'd1);

        send_packet(9'h100, 9'd0, 3'b010, 1'b0, 0);
        check("neg256_x", 32'(cursor_x), 32'd383);
        send_packet(9'h101, 9'd0, 3'b010, 1'b0, 0);
        check("neg255_x", 32'(cursor_x), 32'd128);
        send_packet(9'h1E4, 9'd0, 3'b010, 1'b0, 0);
        check("neg28_x", 32'(cursor_x), 32'd100);
        send_packet(9'h100, 9'd0, 3'b010, 1'b0, 0);
        check("left_clamp_x", 32'(cursor_x), 32'd0);
        check("left_clamp_moved", 32'(moved_snap), 32'd1);

        send_packet(9'd7, 9'd0, 3'b010, 1'b0, 10);
        check("hold_read_count", n_reads, 32'd1);
        check("hold_moved_count", n_moved, 32'd1);
        check("hold_x", 32'(cursor_x), 32'd7);

        send_packet(9'd20, 9'd0, 3'b001, 1'b1, 0);
        check("recenter_x", 32'(cursor_x), 32'd320);
        check("recenter_y", 32'(cursor_y), 32'd240);
        check("recenter_buttons", 32'(buttons), 32'd1);
        check("recenter_btn_change", 32'(bc_snap), 32'd1);
        check("recenter_moved", 32'(moved_snap), 32'd1);

        error_no_ack = 1'b1;
        @(negedge clk);
        error_no_ack = 1'b0;
        check("fault_set", 32'(mouse_fault), 32'd1);
        repeat (3) @(negedge clk);
        check("fault_sticky", 32'(mouse_fault), 32'd1);
        send_packet(9'd1, 9'd0, 3'b001, 1'b0, 0);
        check("fault_pkt_x", 32'(cursor_x), 32'd321);
        check("fault_pkt_moved", 32'(moved_snap), 32'd1);

        d2_x_inc      = 9'd4;
        d2_data_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("speed2_x", 32'(d2_cursor_x), 32'd336);
        check("speed2_y", 32'(d2_cursor_y), 32'd240);
        d2_data_ready = 1'b0;
        @(negedge clk);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset2_fault", 32'(mouse_fault), 32'd0);
        check("reset2_x", 32'(cursor_x), 32'd320);
        check("reset2_buttons", 32'(buttons), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
